// File: rtl/amba3_apb_arbiter_if.sv
// rtl/amba3_apb_arbiter_if.sv - Requester-side and APB3-side signal bundle for the arbiter
interface amba3_apb_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_ready;
  logic [NUM_REQ-1:0]                 req_write;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]                 rsp_valid;
  logic [DATA_WIDTH-1:0]              rsp_rdata;
  logic                               rsp_slverr;

  logic [ADDR_WIDTH-1:0]              paddr;
  logic                               psel;
  logic                               penable;
  logic                               pwrite;
  logic [DATA_WIDTH-1:0]              pwdata;
  logic [DATA_WIDTH-1:0]              prdata;
  logic                               pready;
  logic                               pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_slverr, paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_slverr, paddr, psel, penable, pwrite, pwdata
  );
endinterface

// File: rtl/amba3_apb_arbiter.sv
// rtl/amba3_apb_arbiter.sv - Round-robin arbiter funnelling NUM_REQ requesters onto one APB3 master
module amba3_apb_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic                 pclk,
  input logic                 presetn,
  amba3_apb_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                state_q;
  logic [IDX_W-1:0]      last_grant_q;
  logic [IDX_W-1:0]      grant_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_slverr_q;

  logic                  grant_found;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W-1:0]      cand;
  logic [NUM_REQ-1:0]    req_ready_d;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    req_ready_d = '0;
    if (presetn && state_q == IDLE && grant_found) begin
      req_ready_d[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      grant_q      <= '0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            state_q      <= SETUP;
            grant_q      <= grant_idx;
            last_grant_q <= grant_idx;
            psel_q       <= 1'b1;
            penable_q    <= 1'b0;
            pwrite_q     <= bus.req_write[grant_idx];
            paddr_q      <= bus.req_addr[grant_idx];
            pwdata_q     <= bus.req_wdata[grant_idx];
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          // Address/data stay in their registers so they hold through wait states and idle.
          if (bus.pready) begin
            state_q              <= IDLE;
            psel_q               <= 1'b0;
            penable_q            <= 1'b0;
            rsp_valid_q[grant_q] <= 1'b1;
            rsp_rdata_q          <= pwrite_q ? '0 : bus.prdata;
            rsp_slverr_q         <= bus.pslverr;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_d;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_slverr = rsp_slverr_q;
  assign bus.psel       = psel_q;
  assign bus.penable    = penable_q;
  assign bus.pwrite     = pwrite_q;
  assign bus.paddr      = paddr_q;
  assign bus.pwdata     = pwdata_q;
endmodule

// File: tb/tb_amba3_apb_arbiter.sv
// tb/tb_amba3_apb_arbiter.sv - Directed vector bench for the APB3 round-robin arbiter
module tb_amba3_apb_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic pclk    = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;

  amba3_apb_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  amba3_apb_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  typedef struct {
    logic [3:0]  rv;
    logic [3:0]  wr;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;
    logic [3:0]  e_ready;
    logic        e_psel;
    logic        e_pen;
    logic [31:0] e_paddr;
    logic [3:0]  e_rspv;
    logic [31:0] e_rdata;
    logic        e_slverr;
  } vec_t;

  vec_t tbl[14];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] rv, input logic [3:0] wr, input logic pr,
                              input logic se, input logic [31:0] prd, input logic [3:0] er,
                              input logic ps, input logic pe, input logic [31:0] pa,
                              input logic [3:0] rsv, input logic [31:0] rd, input logic sl);
    vec_t v;
    v.rv = rv; v.wr = wr; v.pready = pr; v.pslverr = se; v.prdata = prd;
    v.e_ready = er; v.e_psel = ps; v.e_pen = pe; v.e_paddr = pa;
    v.e_rspv = rsv; v.e_rdata = rd; v.e_slverr = sl;
    return v;
  endfunction

  initial begin
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    bus.prdata    = '0;
    bus.req_addr[0] = 32'h040;
    bus.req_addr[1] = 32'h100;
    bus.req_addr[2] = 32'h200;
    bus.req_addr[3] = 32'h300;
    for (int i = 0; i < N; i++) bus.req_wdata[i] = 32'hA5A50000 | i;

    // rv, wr, pready, pslverr, prdata | ready, psel, pen, paddr, rsp_valid, rdata, slverr
    tbl[0]  = mk(4'b0010, 4'b0001, 0, 0, 32'h0,        4'b0010, 0, 0, 32'h000, 4'b0000, 32'h0, 0);
    tbl[1]  = mk(4'b0000, 4'b0001, 0, 0, 32'h0,        4'b0000, 1, 0, 32'h100, 4'b0000, 32'h0, 0);
    tbl[2]  = mk(4'b0000, 4'b0001, 1, 0, 32'hDEADBEEF, 4'b0000, 1, 1, 32'h100, 4'b0000, 32'h0, 0);
    tbl[3]  = mk(4'b0001, 4'b0001, 0, 0, 32'h0,        4'b0001, 0, 0, 32'h100, 4'b0010, 32'hDEADBEEF, 0);
    tbl[4]  = mk(4'b0000, 4'b0001, 1, 1, 32'h11111111, 4'b0000, 1, 0, 32'h040, 4'b0000, 32'h0, 0);
    tbl[5]  = mk(4'b0000, 4'b0001, 1, 1, 32'h12345678, 4'b0000, 1, 1, 32'h040, 4'b0000, 32'h0, 0);
    tbl[6]  = mk(4'b0100, 4'b0001, 0, 0, 32'h0,        4'b0100, 0, 0, 32'h040, 4'b0001, 32'h0, 1);
    tbl[7]  = mk(4'b0101, 4'b0001, 0, 0, 32'h0,        4'b0000, 1, 0, 32'h200, 4'b0000, 32'h0, 0);
    tbl[8]  = mk(4'b0101, 4'b0001, 1, 0, 32'hCAFEF00D, 4'b0000, 1, 1, 32'h200, 4'b0000, 32'h0, 0);
    tbl[9]  = mk(4'b0101, 4'b0001, 0, 0, 32'h0,        4'b0001, 0, 0, 32'h200, 4'b0100, 32'hCAFEF00D, 0);
    tbl[10] = mk(4'b0000, 4'b0001, 0, 0, 32'h0,        4'b0000, 1, 0, 32'h040, 4'b0000, 32'h0, 0);
    tbl[11] = mk(4'b0000, 4'b0001, 1, 0, 32'h77777777, 4'b0000, 1, 1, 32'h040, 4'b0000, 32'h0, 0);
    tbl[12] = mk(4'b0000, 4'b0001, 0, 0, 32'h0,        4'b0000, 0, 0, 32'h040, 4'b0001, 32'h0, 0);
    tbl[13] = mk(4'b0000, 4'b0001, 0, 0, 32'h0,        4'b0000, 0, 0, 32'h040, 4'b0000, 32'h0, 0);

    // Reset state with a pending request that must not be accepted.
    bus.req_valid = 4'b1111;
    repeat (2) @(negedge pclk);
    #1;
    chk("rst_ready", bus.req_ready, 4'b0000);
    chk("rst_psel_pen", {bus.psel, bus.penable, bus.pwrite}, 3'b000);
    chk("rst_paddr_pwdata", {bus.paddr, bus.pwdata}, 64'h0);
    chk("rst_rsp", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_slverr}, 37'h0);
    bus.req_valid = '0;

    // Single read, error write, rotation, back-to-back grants.
    for (int i = 0; i < 14; i++) begin
      @(negedge pclk);
      presetn       = 1'b1;
      bus.req_valid = tbl[i].rv;
      bus.req_write = tbl[i].wr;
      bus.pready    = tbl[i].pready;
      bus.pslverr   = tbl[i].pslverr;
      bus.prdata    = tbl[i].prdata;
      #1;
      chk($sformatf("v%0d_ready", i), bus.req_ready, tbl[i].e_ready);
      chk($sformatf("v%0d_psel_pen", i), {bus.psel, bus.penable}, {tbl[i].e_psel, tbl[i].e_pen});
      chk($sformatf("v%0d_paddr", i), bus.paddr, tbl[i].e_paddr);
      chk($sformatf("v%0d_rsp_valid", i), bus.rsp_valid, tbl[i].e_rspv);
      if (tbl[i].e_rspv != 4'b0000)
        chk($sformatf("v%0d_rsp_data", i), {bus.rsp_rdata, bus.rsp_slverr},
            {tbl[i].e_rdata, tbl[i].e_slverr});
    end

    // Write from requester 3 with four wait states; inputs changed after accept must be ignored.
    @(negedge pclk);
    bus.req_valid = 4'b1000;
    bus.req_write = 4'b1000;
    bus.pready    = 1'b0;
    #1;
    chk("ws_ready", bus.req_ready, 4'b1000);
    @(negedge pclk);
    bus.req_valid    = 4'b0000;
    bus.req_write    = 4'b0000;
    bus.req_addr[3]  = 32'hFFF;
    bus.req_wdata[3] = 32'h0;
    #1;
    chk("ws_setup", {bus.psel, bus.penable, bus.paddr}, {2'b10, 32'h300});
    for (int k = 0; k < 5; k++) begin
      @(negedge pclk);
      bus.pready = (k == 4);
      bus.prdata = 32'h55555555;
      #1;
      chk($sformatf("ws_hold%0d", k), {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata},
          {3'b111, 32'h300, 32'hA5A50003});
      chk($sformatf("ws_norsp%0d", k), bus.rsp_valid, 4'b0000);
    end
    @(negedge pclk);
    bus.pready = 1'b0;
    #1;
    chk("ws_rsp", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_slverr}, {4'b1000, 32'h0, 1'b0});
    bus.req_addr[3]  = 32'h300;
    bus.req_wdata[3] = 32'hA5A50003;

    // All requesters held from reset: grants 0,1,2,3,0, three cycles apart.
    @(negedge pclk);
    presetn       = 1'b0;
    bus.req_valid = 4'b1111;
    bus.pready    = 1'b1;
    #1;
    chk("rr_rst_ready", bus.req_ready, 4'b0000);
    for (int c = 0; c < 13; c++) begin
      logic [3:0] exp_rdy;
      @(negedge pclk);
      presetn = 1'b1;
      #1;
      exp_rdy = (c % 3 == 0) ? 4'(1 << ((c / 3) % 4)) : 4'b0000;
      chk($sformatf("rr_c%0d", c), bus.req_ready, exp_rdy);
    end

    // Reset during ACCESS of requester 0's transfer.
    @(negedge pclk);
    bus.req_valid = 4'b0000;
    bus.pready    = 1'b0;
    #1;
    chk("mr_setup", {bus.psel, bus.penable}, 2'b10);
    @(negedge pclk);
    #1;
    chk("mr_access", {bus.psel, bus.penable}, 2'b11);
    presetn    = 1'b0;
    bus.pready = 1'b1;
    @(negedge pclk);
    #1;
    chk("mr_psel_drop", {bus.psel, bus.penable}, 2'b00);
    chk("mr_norsp0", bus.rsp_valid, 4'b0000);
    presetn       = 1'b1;
    bus.pready    = 1'b0;
    bus.req_valid = 4'b1111;
    #1;
    chk("mr_prio0", bus.req_ready, 4'b0001);
    @(negedge pclk);
    bus.req_valid = 4'b0000;
    #1;
    chk("mr_norsp1", bus.rsp_valid, 4'b0000);
    chk("mr_new_setup", {bus.psel, bus.penable, bus.paddr}, {2'b10, 32'h040});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/amba3_apb_arbiter.md
AMBA3_APB_ARBITER -- requirements
Module: amba3_apb_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requester ports (range 2..16).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, giving the APB address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, giving the APB data width.
REQ-004 The block SHALL have port pclk, input, 1 bit: the only clock; all logic samples on its rising edge.
REQ-005 The block SHALL have port presetn, input, 1 bit: reset, synchronous, active-low.
REQ-006 The block SHALL have port req_valid, input, NUM_REQ bits: per-requester transfer request.
REQ-007 The block SHALL have port req_ready, output, NUM_REQ bits: per-requester accept strobe.
REQ-008 The block SHALL have port req_write, input, NUM_REQ bits: per-requester write (1) or read (0).
REQ-009 The block SHALL have port req_addr, input, NUM_REQ*ADDR_WIDTH bits: packed addresses; requester i occupies slice i.
REQ-010 The block SHALL have port req_wdata, input, NUM_REQ*DATA_WIDTH bits: packed write data.
REQ-011 The block SHALL have port rsp_valid, output, NUM_REQ bits: per-requester completion strobe.
REQ-012 The block SHALL have port rsp_rdata, output, DATA_WIDTH bits, and port rsp_slverr, output, 1 bit: response shared by all requesters and qualified by rsp_valid.
REQ-013 The block SHALL have the APB3 master ports paddr (ADDR_WIDTH), psel (1), penable (1), pwrite (1), pwdata (DATA_WIDTH) as outputs, and prdata (DATA_WIDTH), pready (1), pslverr (1) as inputs.

Function
REQ-014 The block SHALL implement the FSM IDLE -> SETUP -> ACCESS -> IDLE.
REQ-015 In IDLE with any req_valid bit set, the block SHALL grant exactly one requester g, drive req_ready[g]=1 combinationally in that cycle, latch that requester's write, addr and wdata, and enter SETUP.
REQ-016 req_ready SHALL be all-zero in every state other than IDLE and whenever req_valid is all-zero.
REQ-017 Grant SHALL be round-robin: search upward from last_grant+1, modulo NUM_REQ, and take the first set req_valid bit; last_grant SHALL update to g on acceptance.
REQ-018 In SETUP the outputs SHALL be psel=1 and penable=0, with paddr, pwrite and pwdata driven from the latched values; the next state SHALL be ACCESS unconditionally.
REQ-019 In ACCESS the outputs SHALL be psel=1 and penable=1, with paddr, pwrite and pwdata held stable; the FSM SHALL remain in ACCESS while pready=0, with no timeout.
REQ-020 On the first ACCESS cycle with pready=1, the block SHALL register prdata (reads only; writes return 0) and pslverr, and enter IDLE.
REQ-021 In the cycle after REQ-020, rsp_valid[g] SHALL be 1 for exactly one cycle, with rsp_rdata and rsp_slverr valid alongside it.
REQ-022 A new grant MAY occur in the same cycle as that rsp_valid pulse.
REQ-023 Latency SHALL be: accept at cycle T, SETUP at T+1, ACCESS at T+2, and with zero wait states rsp_valid at T+3; each pready=0 cycle adds one cycle.
REQ-024 Back-to-back throughput SHALL be one transfer per 3 cycles at zero wait states.
REQ-025 When psel=0, paddr, pwrite and pwdata SHALL hold their last values, and penable SHALL be 0.
REQ-026 A requester that deasserts req_valid before it is granted SHALL lose its request with no side effect; changes to req_* after acceptance SHALL be ignored.
REQ-027 pslverr and prdata SHALL be ignored in every state other than ACCESS with pready=1.

Reset
REQ-028 While presetn=0 at a rising edge, the FSM SHALL be set to IDLE and last_grant to NUM_REQ-1, so requester 0 has first priority.
REQ-029 While presetn=0 at a rising edge, psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata and rsp_slverr SHALL be set to 0.
REQ-030 req_ready SHALL be 0 in every cycle in which presetn=0.
REQ-031 A reset asserted mid-transfer SHALL drop psel at the next edge, and the in-flight transfer SHALL produce no rsp_valid.

Verification
REQ-032 The bench SHALL cover a single read: req_valid=4'b0010, addr 0x100, pready=1 at ACCESS, prdata=0xDEADBEEF -> req_ready[1] pulses at T, psel/penable equal 1/0 at T+1 and 1/1 at T+2, rsp_valid=4'b0010 with rdata 0xDEADBEEF at T+3.
REQ-033 The bench SHALL cover round-robin order: req_valid=4'b1111 held from reset -> grants in order 0,1,2,3,0, with each grant 3 cycles apart.
REQ-034 The bench SHALL cover wait states: a write with pready low for 4 ACCESS cycles -> psel, penable, paddr and pwdata stable for 5 cycles, and rsp_valid at T+7.
REQ-035 The bench SHALL cover an error response: pslverr=1 with pready=1 -> rsp_slverr=1 alongside rsp_valid, and the next transfer returns rsp_slverr=0.
REQ-036 The bench SHALL cover priority rotation: requester 2 is granted, then req_valid=4'b0101 -> requester 0 is granted next, because the search starts at 3 and wraps to 0.
REQ-037 The bench SHALL cover reset mid-transfer: presetn=0 during ACCESS -> psel=0 at the next edge, no rsp_valid, and after release requester 0 has priority.
